// File: rtl/score_pkg.sv
// Shared types and helpers for the score/lives tracker and the HUD.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    COOLDOWN = 2'd1,
    OVER     = 2'd2
  } state_t;

  // Widest score any instance may use; helpers work on this width and callers truncate.
  localparam int MAX_DIGITS = 8;

  // BCD value of one invader row: bottom row earns base, each row upward adds step.
  function automatic logic [4*MAX_DIGITS-1:0] row_points_bcd(input int row, input int num_rows,
                                                             input int base, input int step);
    int v;
    logic [4*MAX_DIGITS-1:0] r;
    v = base + step * (num_rows - 1 - row);
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Magnitude compare of two BCD numbers, most significant differing digit decides.
  function automatic logic bcd_gt(input logic [4*MAX_DIGITS-1:0] a, input logic [4*MAX_DIGITS-1:0] b);
    logic gt;
    logic decided;
    gt = 1'b0;
    decided = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt = (a[4*i +: 4] > b[4*i +: 4]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_add.sv
// DIGITS-wide ripple BCD adder with carry in/out; purely combinational.
module bcd_add #(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout
);

  // Per-digit add with +6 correction when a digit exceeds 9.
  always_comb begin
    logic       c;
    logic [4:0] d;
    c   = cin;
    d   = '0;
    sum = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum[4*i +: 4] = d[3:0];
    end
    cout = c;
  end

endmodule

// File: rtl/score_keeper.sv
// Score, lives, invincibility window, game-over and high score for the game core.
// Kills are queued per row and served lowest row first, one per cycle.
module score_keeper
  import score_pkg::*;
#(
  parameter int NUM_ROWS        = 6,
  parameter int DIGITS          = 3,
  parameter int PTS_BASE        = 10,
  parameter int PTS_STEP        = 10,
  parameter int MAX_LIVES       = 5,
  parameter int START_LIVES     = 3,
  parameter int BONUS_DIGIT     = 2,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int LW              = $clog2(MAX_LIVES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_game,
  input  logic                frame_tick,
  input  logic [NUM_ROWS-1:0] invader_hit,
  input  logic                player_hit,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] high_score,
  output logic [LW-1:0]       lives,
  output logic                invincible,
  output logic                game_over,
  output logic                extra_life
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_t              state, state_nxt;
  logic [NUM_ROWS-1:0] pending, pending_nxt, served;
  logic [SW-1:0]       row_bcd, sum, score_nxt, high_nxt;
  logic                carry, scoring;
  logic [LW-1:0]       lives_nxt, lives_plus;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                bonus_nxt;

  // Pick the lowest pending row and look up its BCD point value.
  always_comb begin
    served  = pending & (~pending + NUM_ROWS'(1));
    row_bcd = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (served[i]) row_bcd = SW'(row_points_bcd(i, NUM_ROWS, PTS_BASE, PTS_STEP));
    end
    scoring = (state != OVER) && (|served);
  end

  bcd_add #(.DIGITS(DIGITS)) u_add (
    .a    (score),
    .b    (row_bcd),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Next-state, scoring, lives and cooldown timer.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    score_nxt   = score;
    high_nxt    = high_score;
    lives_nxt   = lives;
    lives_plus  = lives;
    cnt_nxt     = cnt;
    bonus_nxt   = 1'b0;
    if (new_game) begin
      state_nxt   = PLAY;
      pending_nxt = '0;
      score_nxt   = '0;
      lives_nxt   = LW'(START_LIVES);
      cnt_nxt     = '0;
    end else begin
      if (scoring) begin
        if (carry) begin
          score_nxt = ALL_NINES;
        end else begin
          score_nxt = sum;
          bonus_nxt = (sum[SW-1:4*BONUS_DIGIT] != score[SW-1:4*BONUS_DIGIT]);
        end
      end
      if (bonus_nxt && (lives < LW'(MAX_LIVES))) lives_plus = lives + LW'(1);
      lives_nxt = lives_plus;
      case (state)
        PLAY: begin
          pending_nxt = (pending & ~served) | invader_hit;
          if (player_hit) begin
            // A bonus landing in the same cycle as the hit can keep the player alive.
            if (lives_plus > LW'(1)) begin
              lives_nxt = lives_plus - LW'(1);
              cnt_nxt   = CW'(COOLDOWN_FRAMES);
              state_nxt = COOLDOWN;
            end else begin
              lives_nxt = '0;
              state_nxt = OVER;
            end
          end
        end
        COOLDOWN: begin
          pending_nxt = (pending & ~served) | invader_hit;
          if (frame_tick) begin
            cnt_nxt = cnt - CW'(1);
            if (cnt <= CW'(1)) begin
              cnt_nxt   = '0;
              state_nxt = PLAY;
            end
          end
        end
        OVER: begin
          pending_nxt = '0;
          // Score is frozen in OVER, so comparing every cycle equals comparing on entry.
          if (bcd_gt((4*MAX_DIGITS)'(score), (4*MAX_DIGITS)'(high_score))) high_nxt = score;
        end
        default: state_nxt = PLAY;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PLAY;
      pending    <= '0;
      score      <= '0;
      high_score <= '0;
      lives      <= LW'(START_LIVES);
      cnt        <= '0;
      extra_life <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      score      <= score_nxt;
      high_score <= high_nxt;
      lives      <= lives_nxt;
      cnt        <= cnt_nxt;
      extra_life <= bonus_nxt;
    end
  end

  assign invincible = (state == COOLDOWN);
  assign game_over  = (state == OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized play,
// every cycle compared against an integer-arithmetic reference model.
module tb_score_keeper;

  localparam int NUM_ROWS = 6;
  localparam int MAXL     = 5;
  localparam int STARTL   = 3;
  localparam int COOL     = 60;
  localparam int SMAX     = 999;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       frame_tick = 1'b0;
  logic [5:0] invader_hit = '0;
  logic       player_hit = 1'b0;
  logic [11:0] score, high_score;
  logic [2:0] lives;
  logic       invincible, game_over, extra_life;

  int errors = 0;
  int checks = 0;

  // reference model state (plain integers, mode: 0 play, 1 cooldown, 2 over)
  int m_score, m_high, m_lives, m_mode, m_cool;
  bit m_xl;
  bit m_pend [NUM_ROWS];

  score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .new_game    (new_game),
    .frame_tick  (frame_tick),
    .invader_hit (invader_hit),
    .player_hit  (player_hit),
    .score       (score),
    .high_score  (high_score),
    .lives       (lives),
    .invincible  (invincible),
    .game_over   (game_over),
    .extra_life  (extra_life)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset(input bit keep_high);
    m_score = 0;
    if (!keep_high) m_high = 0;
    m_lives = STARTL;
    m_mode  = 0;
    m_cool  = 0;
    m_xl    = 0;
    for (int i = 0; i < NUM_ROWS; i++) m_pend[i] = 0;
  endtask

  task automatic model_step();
    int srv, ns, nl, pts;
    bit bonus;
    if (new_game) begin
      model_reset(1);
      return;
    end
    srv = -1;
    if (m_mode != 2)
      for (int i = NUM_ROWS - 1; i >= 0; i--) if (m_pend[i]) srv = i;
    ns = m_score;
    bonus = 0;
    if (srv >= 0) begin
      pts = 10 + 10 * (NUM_ROWS - 1 - srv);
      if (m_score + pts > SMAX) ns = SMAX;
      else begin
        ns = m_score + pts;
        bonus = (ns / 100) != (m_score / 100);
      end
    end
    nl = m_lives + ((bonus && m_lives < MAXL) ? 1 : 0);
    if (m_mode == 2) begin
      if (m_score > m_high) m_high = m_score;
      for (int i = 0; i < NUM_ROWS; i++) m_pend[i] = 0;
    end else begin
      if (srv >= 0) m_pend[srv] = 0;
      for (int i = 0; i < NUM_ROWS; i++) if (invader_hit[i]) m_pend[i] = 1;
      if (m_mode == 0 && player_hit) begin
        if (nl - 1 >= 1) begin
          nl = nl - 1;
          m_mode = 1;
          m_cool = COOL;
        end else begin
          nl = 0;
          m_mode = 2;
        end
      end else if (m_mode == 1 && frame_tick) begin
        m_cool--;
        if (m_cool == 0) m_mode = 0;
      end
    end
    m_score = ns;
    m_lives = nl;
    m_xl    = bonus;
  endtask

  task automatic compare_all();
    chk("score", 32'(score), 32'(to_bcd(m_score)));
    chk("high_score", 32'(high_score), 32'(to_bcd(m_high)));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("invincible", 32'(invincible), 32'(m_mode == 1));
    chk("game_over", 32'(game_over), 32'(m_mode == 2));
    chk("extra_life", 32'(extra_life), 32'(m_xl));
  endtask

  // one clock: DUT and model both consume the currently driven inputs, then inputs idle
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    invader_hit = '0;
    player_hit  = 1'b0;
    new_game    = 1'b0;
    frame_tick  = 1'b0;
  endtask

  task automatic lose_life();
    int n;
    player_hit = 1'b1;
    step();
    n = 0;
    while (m_mode == 1 && n < 200) begin
      frame_tick = 1'b1;
      step();
      n++;
    end
    chk("cooldown_bound", 32'(m_mode == 1), 32'(0));
  endtask

  initial begin
    int n;
    model_reset(0);
    #12;
    compare_all();
    rst = 1'b0;
    chk("reset_lives", 32'(lives), 32'(3));

    // single row-5 kill
    invader_hit = 6'b100000;
    step();
    step();
    chk("row5_score", 32'(score), 32'h010);

    // two kills in one cycle are serialised, second add crosses 100
    new_game = 1'b1;
    step();
    invader_hit = 6'b000011;
    step();
    step();
    chk("dual_first", 32'(score), 32'h060);
    step();
    chk("dual_second", 32'(score), 32'h110);
    chk("dual_bonus", 32'(extra_life), 32'(1));
    chk("dual_lives", 32'(lives), 32'(4));

    // saturation at 999
    n = 0;
    while (m_score < SMAX && n < 60) begin
      invader_hit = 6'b000001;
      step();
      n++;
    end
    invader_hit = 6'b111111;
    step();
    for (int i = 0; i < 8; i++) step();
    chk("saturated", 32'(score), 32'h999);
    chk("sat_lives_cap", 32'(lives), 32'(MAXL));

    // invincibility window
    new_game = 1'b1;
    step();
    player_hit = 1'b1;
    step();
    chk("hit_lives", 32'(lives), 32'(2));
    chk("hit_invincible", 32'(invincible), 32'(1));
    player_hit = 1'b1;
    step();
    chk("hit_ignored", 32'(lives), 32'(2));
    for (int i = 0; i < COOL - 1; i++) begin
      frame_tick = 1'b1;
      step();
    end
    chk("window_open", 32'(invincible), 32'(1));
    frame_tick = 1'b1;
    step();
    chk("window_closed", 32'(invincible), 32'(0));

    // first game over establishes high score 080
    new_game = 1'b1;
    step();
    invader_hit = 6'b010001;
    step();
    step();
    step();
    chk("score80", 32'(score), 32'h080);
    for (int i = 0; i < 3; i++) lose_life();
    step();
    chk("high80", 32'(high_score), 32'h080);

    // second game: 120 beats 080, hits ignored after game over, new game keeps high
    new_game = 1'b1;
    step();
    invader_hit = 6'b000001;
    step();
    invader_hit = 6'b000001;
    step();
    step();
    chk("score120", 32'(score), 32'h120);
    for (int i = 0; i < 3; i++) lose_life();
    chk("last_life", 32'(lives), 32'(1));
    player_hit = 1'b1;
    step();
    chk("over_flag", 32'(game_over), 32'(1));
    chk("over_lives", 32'(lives), 32'(0));
    step();
    chk("high120", 32'(high_score), 32'h120);
    invader_hit = 6'b111111;
    step();
    step();
    step();
    chk("over_frozen", 32'(score), 32'h120);
    new_game = 1'b1;
    step();
    chk("ng_score", 32'(score), 32'h000);
    chk("ng_lives", 32'(lives), 32'(3));
    chk("ng_high", 32'(high_score), 32'h120);

    // player hit on the last life in the same cycle as a bonus crossing
    lose_life();
    lose_life();
    invader_hit = 6'b000001;
    step();
    step();
    invader_hit = 6'b000010;
    step();
    player_hit = 1'b1;
    step();
    chk("sim_lives", 32'(lives), 32'(1));
    chk("sim_cool", 32'(invincible), 32'(1));
    chk("sim_over", 32'(game_over), 32'(0));
    chk("sim_bonus", 32'(extra_life), 32'(1));
    frame_tick = 1'b1;
    step();
    // asynchronous reset in the middle of the window
    #2 rst = 1'b1;
    #1;
    model_reset(0);
    compare_all();
    #2 rst = 1'b0;

    // randomized play
    for (int c = 0; c < 4000; c++) begin
      invader_hit = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      player_hit  = ($urandom_range(0, 39) == 0);
      frame_tick  = ($urandom_range(0, 1) == 0);
      new_game    = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Parametrised score and lives tracker for the game core.
- Takes per-row invader hit strobes from the collision logic and a player hit strobe.
- Keeps a saturating BCD score, a lives counter with extra-life bonuses, a post-hit invincibility window, a game-over state and a high score that persists across games.
- Feeds the HUD/text renderer and the top-level game controller.

Parameters:
- NUM_ROWS, 6, number of invader rows; width of invader_hit.
- DIGITS, 3, score width in BCD digits.
- PTS_BASE, 10, points for the bottom row (row NUM_ROWS-1); binary value, must be < 10^DIGITS.
- PTS_STEP, 10, extra points per row going upward: row i is worth PTS_BASE + PTS_STEP*(NUM_ROWS-1-i).
- MAX_LIVES, 5, lives ceiling.
- START_LIVES, 3, lives at reset and at new game; must be <= MAX_LIVES.
- BONUS_DIGIT, 2, an extra life is granted each time the score crosses a multiple of 10^BONUS_DIGIT; must be < DIGITS.
- COOLDOWN_FRAMES, 60, length of the invincibility window in frame_tick pulses.
- LW, $clog2(MAX_LIVES+1), width of lives.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- new_game  in  1  sync pulse: restart game, keep high score
- frame_tick  in  1  one-cycle pulse per video frame
- invader_hit  in  NUM_ROWS  per-row kill strobes; multiple bits may be set
- player_hit  in  1  player collision strobe
- score  out  4*DIGITS  current score, BCD
- high_score  out  4*DIGITS  best score since rst, BCD
- lives  out  LW  remaining lives
- invincible  out  1  high during COOLDOWN
- game_over  out  1  high in OVER
- extra_life  out  1  one-cycle pulse when a bonus life is granted

Behaviour:
- Reset (rst async) values:
  - score=0, high_score=0, lives=START_LIVES
  - pending=0, state=PLAY, cooldown counter=0
  - invincible=0, game_over=0, extra_life=0
- new_game: synchronous, highest priority. Same values as rst, except high_score is retained.
- Hit queue:
  - Each cycle, pending <= (pending & ~served) | invader_hit, except in OVER, where incoming hits are dropped.
  - Each cycle, the lowest set bit of pending (if any) is served: its row value is added to score.
  - Throughput is one row per cycle. score reflects a served row 1 cycle after service.
  - Simultaneous kills are never lost, only serialised. A repeated strobe on an already-pending row merges with it (one award).
- Score arithmetic:
  - Row values are precomputed BCD constants.
  - Addition is DIGITS-wide BCD with carry.
  - If the add carries out of the top digit, score saturates at all 9s. Further adds leave it unchanged, with no bonus.
- Extra life:
  - Granted when the digits at index >= BONUS_DIGIT change value in a non-saturating add.
  - extra_life pulses in the same cycle the score register updates.
  - lives increments only if lives < MAX_LIVES; the pulse fires regardless.
- States:
  - PLAY
    - player_hit with lives>1 -> lives-1, counter=COOLDOWN_FRAMES, go to COOLDOWN.
    - player_hit with lives==1 -> lives=0, go to OVER.
  - COOLDOWN
    - invincible=1; player_hit is ignored.
    - Counter decrements on frame_tick. On the tick that reaches 0 -> PLAY.
    - Scoring continues.
  - OVER
    - game_over=1; pending is cleared; scoring and player_hit are ignored.
    - On the OVER entry cycle: if score > high_score (BCD magnitude compare), high_score <= score.
    - Leaves OVER only via new_game or rst.
- Simultaneous player_hit and bonus in the same cycle:
  - Net lives = lives - 1 + (bonus && lives<MAX_LIVES).
  - If the net result is >= 1, go to COOLDOWN, not OVER. Only a net 0 enters OVER.
- player_hit is level-sampled each cycle. The upstream block guarantees one-cycle strobes.

Decomposition:
- Package score_pkg:
  - state enum {PLAY, COOLDOWN, OVER}
  - function row_points_bcd(row) computing the BCD constant per row
  - function bcd_gt for the magnitude compare
- One sub-module, bcd_add: DIGITS-wide combinational BCD adder with carry-out. It is reused later by the HUD.

Test Plan:
- Reset, then invader_hit=6'b100000 (row 5) -> score=0x010 after 1 cycle; lives=3; extra_life=0.
- invader_hit=6'b000011 in one cycle (rows 0,1, worth 60 and 50) -> score 0x060 at cycle+1, 0x110 at cycle+2; extra_life pulses at cycle+2; lives 3->4.
- Force score to 0x990, hit row 0 -> score=0x999 (saturated); no extra_life; later hits leave 0x999.
- player_hit at lives=3 -> lives=2, invincible=1; second player_hit during window ignored; after 60 frame_ticks invincible=0.
- lives=1 with score 0x120 > high_score 0x080, player_hit -> lives=0, game_over=1, high_score=0x120; invader hits ignored; new_game -> score=0, lives=3, high_score still 0x120.
- player_hit at lives=1 in the same cycle a bonus crossing occurs -> lives stays 1, state COOLDOWN, game_over=0. Assert rst mid-COOLDOWN -> all outputs at reset values immediately.
